sdram_bist: RTL and testbench

SDRAM_BIST -- requirements
Module: sdram_bist

---
 rtl/sdram_bist.sv | 191 +++++++++++++++++++
 tb/tb_sdram_bist.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist.sv
// Pattern write/read-back BIST acting as manager on the SDRAM core request/accept/ack handshake.
// Define SDRAM_BIST_TIMEOUT_EN to compile in the per-request watchdog.
module sdram_bist #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           NUM_WORDS  = 1024,
    parameter int unsigned           ADDR_STEP  = 4,
    parameter int unsigned           TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic                  timeout,
    output logic [3:0]            wr,
    output logic                  rd,
    output logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic                  accept,
    input  logic                  ack,
    input  logic                  error,
    input  logic [DATA_WIDTH-1:0] read_data
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH} state_t;

    localparam logic [15:0]           LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

    state_t                state, state_n;
    logic                  issued, issued_n;
    logic [15:0]           idx;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           seed_q;
    logic [DATA_WIDTH-1:0] pattern;
    logic                  rd_phase, last_word;
    logic                  start_acc, acked, fail_evt;
    logic                  timed_out;

    assign pattern   = DATA_WIDTH'(cur_addr) ^ DATA_WIDTH'(seed_q);
    assign rd_phase  = (state == RD_REQ) || (state == RD_WAIT);
    assign last_word = (idx == LAST_IDX);
    assign len       = '0;
    assign timeout   = timed_out;

`ifdef SDRAM_BIST_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              active, tmo;

    assign active = (state == WR_REQ) || (state == WR_WAIT) ||
                    (state == RD_REQ) || (state == RD_WAIT);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Each request opens with one idle cycle (issued low), so strobes always drop
    // for a cycle after an accept even when the next word follows immediately.
    always_comb begin
        state_n   = state;
        issued_n  = issued;
        start_acc = 1'b0;
        acked     = 1'b0;
        fail_evt  = 1'b0;
`ifdef SDRAM_BIST_TIMEOUT_EN
        tmo       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_n   = WR_REQ;
                end
            end
            WR_REQ, RD_REQ: begin
                if (!issued) begin
                    issued_n = 1'b1;
                end else if (accept) begin
                    issued_n = 1'b0;
                    if (ack) acked = 1'b1;
                    else     state_n = rd_phase ? RD_WAIT : WR_WAIT;
                end
            end
            WR_WAIT, RD_WAIT: acked = ack;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (acked) begin
            fail_evt = error || (rd_phase && (read_data != pattern));
            if (last_word) state_n = rd_phase ? FINISH : RD_REQ;
            else           state_n = rd_phase ? RD_REQ : WR_REQ;
        end

`ifdef SDRAM_BIST_TIMEOUT_EN
        if (active && !acked && !(issued && accept) && (wait_cnt == WAIT_W'(TIMEOUT))) begin
            tmo      = 1'b1;
            issued_n = 1'b0;
            state_n  = FINISH;
        end
`endif
    end

    always_comb begin
        wr         = '0;
        rd         = 1'b0;
        addr       = '0;
        write_data = '0;
        if (issued && state == WR_REQ) begin
            wr         = 4'hF;
            addr       = cur_addr;
            write_data = pattern;
        end
        if (issued && state == RD_REQ) begin
            rd   = 1'b1;
            addr = cur_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued          <= 1'b0;
            idx             <= '0;
            cur_addr        <= '0;
            seed_q          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
        end else begin
            issued <= issued_n;
            if (start_acc) begin
                seed_q          <= seed;
                idx             <= '0;
                cur_addr        <= BASE_ADDR;
                busy            <= 1'b1;
                done            <= 1'b0;
                pass            <= 1'b0;
                fail_count      <= '0;
                first_fail_addr <= '0;
            end
            if (acked) begin
                if (last_word) begin
                    idx      <= '0;
                    cur_addr <= BASE_ADDR;
                end else begin
                    idx      <= idx + 16'd1;
                    cur_addr <= cur_addr + STEP;
                end
            end
            if (fail_evt) begin
                if (fail_count != '1) fail_count <= fail_count + 16'd1;
                if (fail_count == '0) first_fail_addr <= cur_addr;
            end
            if (state == FINISH) begin
                done <= 1'b1;
                pass <= (fail_count == '0) && !timed_out;
                busy <= 1'b0;
            end
        end
    end

`ifdef SDRAM_BIST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (state_n != state || acked) wait_cnt <= '0;
            else if (active)               wait_cnt <= wait_cnt + WAIT_W'(1);
            if (start_acc) timed_out <= 1'b0;
            else if (tmo)  timed_out <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: behavioural memory responder plus a word-list reference model.
module tb_sdram_bist;
    localparam int unsigned NW   = 4;
    localparam int unsigned STEP = 4;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] seed;
    logic        busy, done, pass, timeout;
    logic [15:0] fail_count;
    logic [31:0] first_fail_addr, addr, write_data, read_data;
    logic [3:0]  wr;
    logic        rd, accept, ack, error;
    logic [7:0]  len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_bist #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE),
        .NUM_WORDS(NW), .ADDR_STEP(STEP), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr), .timeout(timeout),
        .wr(wr), .rd(rd), .len(len), .addr(addr), .write_data(write_data),
        .accept(accept), .ack(ack), .error(error), .read_data(read_data)
    );

    // Responder configuration and bookkeeping
    int unsigned acc_dly = 0, ack_dly = 0;
    bit          rand_dly = 0, never_accept = 0, stray = 0;
    bit          corrupt_en = 0, err_en = 0;
    logic [31:0] corrupt_addr = '0, err_addr = '0;
    int          rphase = 0, cnt = 0, cur_acc = 0, cur_ack = 0;
    bit          cap_wr = 0, just_acc = 0;
    logic [31:0] cap_addr = '0, cap_data = '0;
    int          stab_err = 0, post_acc_err = 0;
    logic [31:0] mem [logic [31:0]];

    typedef struct packed { logic is_wr; logic [31:0] a; logic [31:0] d; } txn_t;
    txn_t log_q[$];

    task automatic complete();
        logic [31:0] d;
        ack    = 1'b1;
        rphase = 0;
        if (cap_wr) begin
            mem[cap_addr] = cap_data;
            error = err_en && (cap_addr == err_addr);
            log_q.push_back({1'b1, cap_addr, cap_data});
        end else begin
            d = mem.exists(cap_addr) ? mem[cap_addr] : 32'h0;
            if (corrupt_en && cap_addr == corrupt_addr) d = d ^ 32'h1;
            read_data = d;
            log_q.push_back({1'b0, cap_addr, d});
        end
    endtask

    initial begin
        accept = 1'b0; ack = 1'b0; error = 1'b0; read_data = '0;
        forever begin
            @(negedge clk);
            accept = 1'b0; ack = 1'b0; error = 1'b0;
            if (just_acc) begin
                if (wr != 4'h0 || rd) post_acc_err++;
                just_acc = 0;
            end
            if (rst) begin
                rphase = 0;
            end else begin
                if (rphase == 0) begin
                    if (wr != 4'h0 || rd) begin
                        if ((wr != 4'h0 && wr != 4'hF) || (wr != 4'h0 && rd)) stab_err++;
                        cap_wr   = (wr != 4'h0);
                        cap_addr = addr;
                        cap_data = write_data;
                        cnt      = 0;
                        cur_acc  = rand_dly ? int'($urandom_range(0, 3)) : int'(acc_dly);
                        cur_ack  = rand_dly ? int'($urandom_range(0, 4)) : int'(ack_dly);
                        rphase   = 1;
                    end else if (stray) begin
                        accept = 1'b1; ack = 1'b1; error = 1'b1; read_data = $urandom;
                    end
                end else if (rphase == 1) begin
                    if (((wr != 4'h0) != cap_wr) || (rd == cap_wr) || (addr != cap_addr) ||
                        (cap_wr && write_data != cap_data)) stab_err++;
                end
                if (rphase == 1 && !never_accept) begin
                    if (cnt == cur_acc) begin
                        accept   = 1'b1;
                        just_acc = 1;
                        cnt      = 0;
                        if (cur_ack == 0) complete();
                        else rphase = 2;
                    end else cnt++;
                end else if (rphase == 2) begin
                    cnt++;
                    if (cnt == cur_ack) complete();
                end
            end
        end
    end

    // Reference model: NW writes of (addr ^ seed) in address order, then NW reads of the same addresses.
    function automatic int log_mismatches(input logic [31:0] s);
        int          m;
        logic [31:0] a;
        m = 0;
        if (log_q.size() != 2 * NW) return 100 + log_q.size();
        for (int k = 0; k < 2 * int'(NW); k++) begin
            a = BASE + 32'((k % NW) * STEP);
            if (log_q[k].is_wr != (k < int'(NW)) || log_q[k].a != a) m++;
            if (k < int'(NW) && log_q[k].d != (a ^ s)) m++;
        end
        return m;
    endfunction

    task automatic set_env(input int unsigned a, input int unsigned k, input bit r);
        acc_dly = a; ack_dly = k; rand_dly = r;
        corrupt_en = 0; err_en = 0; never_accept = 0; stray = 0;
    endtask

    task automatic pulse_start(input logic [31:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_once(input logic [31:0] s, input int limit, output bit fin, output int cyc);
        log_q.delete();
        stab_err = 0; post_acc_err = 0;
        pulse_start(s);
        fin = 0; cyc = 0;
        while (cyc < limit && !fin) begin
            @(negedge clk);
            cyc++;
            if (done) fin = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, pass, fail_count, first_fail_addr, timeout, wr, rd, len, addr, write_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b fc=%0h ffa=%0h to=%b wr=%0h rd=%b len=%0h addr=%0h wd=%0h want all 0",
                     busy, done, pass, fail_count, first_fail_addr, timeout, wr, rd, len, addr, write_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ideal();
        bit fin; int cyc;
        set_env(0, 0, 0);
        run_once(32'hA5A5A5A5, 500, fin, cyc);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL ideal_done got %b want 1", fin); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass got %b want 1", pass); end
        checks++; if (fail_count !== 16'd0) begin errors++; $display("FAIL ideal_fail_count got %0d want 0", fail_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ideal_busy got %b want 0", busy); end
        checks++; if (log_mismatches(32'hA5A5A5A5) !== 0) begin errors++; $display("FAIL ideal_txn_log got %0d mismatches want 0", log_mismatches(32'hA5A5A5A5)); end
        checks++; if (post_acc_err !== 0) begin errors++; $display("FAIL ideal_strobe_drop got %0d violations want 0", post_acc_err); end
        repeat (5) @(negedge clk);
        checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL ideal_done_held got %b want 11", {done, pass}); end
    endtask

    task automatic test_delayed();
        bit fin; int cyc;
        set_env(3, 5, 0);
        run_once(32'hA5A5A5A5, 1000, fin, cyc);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL delayed_done got %b want 1", fin); end
        checks++; if ({pass, fail_count, timeout} !== {1'b1, 16'd0, 1'b0}) begin errors++; $display("FAIL delayed_result got pass=%b fc=%0d to=%b want pass=1 fc=0 to=0", pass, fail_count, timeout); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL delayed_req_stable got %0d violations want 0", stab_err); end
        checks++; if (post_acc_err !== 0) begin errors++; $display("FAIL delayed_strobe_drop got %0d violations want 0", post_acc_err); end
        checks++; if (log_mismatches(32'hA5A5A5A5) !== 0) begin errors++; $display("FAIL delayed_txn_log got %0d mismatches want 0", log_mismatches(32'hA5A5A5A5)); end
        checks++; if (cyc < 64) begin errors++; $display("FAIL delayed_duration got %0d cycles want >= 64", cyc); end
    endtask

    task automatic test_corrupt();
        bit fin; int cyc;
        set_env(0, 0, 0);
        corrupt_en = 1; corrupt_addr = 32'd8;
        run_once(32'h1234_5678, 500, fin, cyc);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL corrupt_done got %b want 1", fin); end
        checks++; if (fail_count !== 16'd1) begin errors++; $display("FAIL corrupt_fail_count got %0d want 1", fail_count); end
        checks++; if (first_fail_addr !== 32'd8) begin errors++; $display("FAIL corrupt_first_addr got %0h want 8", first_fail_addr); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass got %b want 0", pass); end
        corrupt_en = 0;
    endtask

    task automatic test_write_error();
        bit fin; int cyc;
        set_env(0, 0, 0);
        err_en = 1; err_addr = 32'd4;
        run_once(32'hDEAD_BEEF, 500, fin, cyc);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL werr_done got %b want 1", fin); end
        checks++; if (fail_count !== 16'd1) begin errors++; $display("FAIL werr_fail_count got %0d want 1", fail_count); end
        checks++; if (first_fail_addr !== 32'd4) begin errors++; $display("FAIL werr_first_addr got %0h want 4", first_fail_addr); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL werr_pass got %b want 0", pass); end
        err_en = 0;
    endtask

    task automatic test_stray();
        bit fin; int cyc;
        set_env(0, 0, 0);
        stray = 1;
        repeat (4) @(negedge clk);
        run_once(32'h0F0F_1234, 500, fin, cyc);
        checks++; if ({fin, pass, fail_count} !== {1'b1, 1'b1, 16'd0}) begin errors++; $display("FAIL stray_result got done=%b pass=%b fc=%0d want 1 1 0", fin, pass, fail_count); end
        checks++; if (log_mismatches(32'h0F0F_1234) !== 0) begin errors++; $display("FAIL stray_txn_log got %0d mismatches want 0", log_mismatches(32'h0F0F_1234)); end
        stray = 0;
    endtask

    task automatic test_busy_start();
        bit fin; int cyc; bit was_busy;
        set_env(1, 2, 0);
        log_q.delete();
        pulse_start(32'hCAFE_0001);
        repeat (8) @(negedge clk);
        was_busy = busy;
        pulse_start(32'h5555_AAAA);
        fin = 0; cyc = 0;
        while (cyc < 500 && !fin) begin
            @(negedge clk);
            cyc++;
            if (done) fin = 1;
        end
        checks++; if (was_busy !== 1'b1) begin errors++; $display("FAIL busy_mid_run got %b want 1", was_busy); end
        checks++; if ({fin, pass} !== 2'b11) begin errors++; $display("FAIL busy_start_result got done=%b pass=%b want 1 1", fin, pass); end
        checks++; if (log_mismatches(32'hCAFE_0001) !== 0) begin errors++; $display("FAIL busy_start_seed got %0d mismatches want 0", log_mismatches(32'hCAFE_0001)); end
    endtask

    task automatic test_reset_midrun();
        bit fin; int cyc; int n;
        set_env(0, 5, 0);
        log_q.delete();
        pulse_start(32'h7777_0000);
        n = 0;
        while (n < 500 && !(rphase == 2 && !cap_wr)) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 500) begin errors++; $display("FAIL midrun_reach_rd_wait got %0d cycles want < 500", n); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, pass, fail_count, first_fail_addr, timeout, wr, rd, len, addr, write_data} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got busy=%b done=%b pass=%b fc=%0h wr=%0h rd=%b addr=%0h wd=%0h want all 0",
                     busy, done, pass, fail_count, wr, rd, addr, write_data);
        end
        rst = 1'b0;
        @(negedge clk);
        run_once(32'h2468_ACE0, 1000, fin, cyc);
        checks++; if ({fin, pass, fail_count} !== {1'b1, 1'b1, 16'd0}) begin errors++; $display("FAIL midrun_rerun got done=%b pass=%b fc=%0d want 1 1 0", fin, pass, fail_count); end
        checks++; if (log_mismatches(32'h2468_ACE0) !== 0) begin errors++; $display("FAIL midrun_rerun_log got %0d mismatches want 0", log_mismatches(32'h2468_ACE0)); end
    endtask

    task automatic test_random();
        bit fin; int cyc;
        logic [31:0] s, exp_ffa;
        int unsigned mode, wc, we;
        logic [15:0] exp_fc;
        for (int it = 0; it < 8; it++) begin
            set_env(0, 0, 1);
            s    = $urandom;
            mode = $urandom_range(0, 3);
            wc   = $urandom_range(0, NW - 1);
            we   = $urandom_range(0, NW - 1);
            corrupt_en = mode[0]; corrupt_addr = BASE + 32'(wc * STEP);
            err_en     = mode[1]; err_addr     = BASE + 32'(we * STEP);
            exp_fc  = 16'(mode[0]) + 16'(mode[1]);
            exp_ffa = mode[1] ? err_addr : (mode[0] ? corrupt_addr : 32'h0);
            run_once(s, 1000, fin, cyc);
            checks++; if (fin !== 1'b1) begin errors++; $display("FAIL rand%0d_done got %b want 1", it, fin); end
            checks++; if (fail_count !== exp_fc) begin errors++; $display("FAIL rand%0d_fail_count got %0d want %0d", it, fail_count, exp_fc); end
            checks++; if (first_fail_addr !== exp_ffa) begin errors++; $display("FAIL rand%0d_first_addr got %0h want %0h", it, first_fail_addr, exp_ffa); end
            checks++; if (pass !== (exp_fc == 16'd0)) begin errors++; $display("FAIL rand%0d_pass got %b want %b", it, pass, exp_fc == 16'd0); end
            checks++; if (log_mismatches(s) !== 0) begin errors++; $display("FAIL rand%0d_txn_log got %0d mismatches want 0", it, log_mismatches(s)); end
            checks++; if (stab_err !== 0) begin errors++; $display("FAIL rand%0d_req_stable got %0d violations want 0", it, stab_err); end
        end
        set_env(0, 0, 0);
    endtask

`ifdef SDRAM_BIST_TIMEOUT_EN
    task automatic test_timeout();
        bit fin; int n;
        set_env(0, 0, 0);
        never_accept = 1;
        pulse_start(32'h0BAD_F00D);
        repeat (4) @(negedge clk);
        pulse_start(32'hFFFF_0000);
        checks++; if ({wr, addr, write_data} !== {4'hF, BASE, BASE ^ 32'h0BAD_F00D}) begin errors++; $display("FAIL timeout_busy_start got wr=%0h addr=%0h wd=%0h want F %0h %0h", wr, addr, write_data, BASE, BASE ^ 32'h0BAD_F00D); end
        n = 6; fin = 0;
        while (n < 100 && !fin) begin
            @(negedge clk);
            n++;
            if (done) fin = 1;
        end
        checks++; if ({fin, timeout, pass} !== 3'b110) begin errors++; $display("FAIL timeout_result got done=%b to=%b pass=%b want 1 1 0", fin, timeout, pass); end
        checks++; if (n < 16 || n > 20) begin errors++; $display("FAIL timeout_latency got %0d cycles want 16..20", n); end
        checks++; if ({wr, rd, busy, fail_count} !== '0) begin errors++; $display("FAIL timeout_idle got wr=%0h rd=%b busy=%b fc=%0d want 0", wr, rd, busy, fail_count); end
        never_accept = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_ideal();
        test_delayed();
        test_corrupt();
        test_write_error();
        test_stray();
        test_busy_start();
        test_reset_midrun();
        test_random();
`ifdef SDRAM_BIST_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
